ofmap_writer: RTL
=================

// Module: ofmap_writer
// PURPOSE
// Drain-side counterpart of the PE array: accepts the psum stream leaving the array and writes it into the
// ofmap bank, accumulating across channel passes (read-modify-write) so the bank holds final ofmap values.
// Sits between PE_array psum output and the ofmap memory; the memory holds filter-major, row-major words.
// PARAMETERS
// DATA_W  16  psum / ofmap word width
// DIM_W    8  width of runtime dimension inputs
// ADDR_W  12  ofmap bank address width
// PORTS
// clk           in   1       clock
// rst           in   1       async reset, active-high
// M             in   DIM_W   filters per layer (p*t); sampled on start
// E             in   DIM_W   ofmap rows (H-R+1); sampled on start
// F             in   DIM_W   ofmap cols (W-S+1); sampled on start
// N_PASS        in   DIM_W   channel passes to accumulate; sampled on start
// start         in   1       begin layer; ignored unless IDLE
// psum_valid    in   1       psum_data valid
// psum_ready    out  1       writer can accept
// psum_data     in   DATA_W  psum word
// psum_last     in   1       asserted with final word of a pass
// rd_en         out  1       ofmap bank read strobe
// rd_addr       out  ADDR_W  read address
// rd_data       in   DATA_W  read data, valid 1 cycle after rd_en
// wr_en         out  1       ofmap bank write strobe
// wr_addr       out  ADDR_W  write address
// wr_data       out  DATA_W  write data
// busy          out  1       high outside IDLE
// done          out  1       1-cycle pulse when all passes written
// err           out  1       sticky: psum_last position mismatch; cleared by start
// BEHAVIOUR
// - Reset: state IDLE; psum_ready, rd_en, wr_en, busy, done, err = 0; addresses/data = 0; counters = 0.
// - Transfer occurs when psum_valid && psum_ready. Stream order per pass: m 0..M-1, e 0..E-1, f 0..F-1.
// - addr = m*E*F + e*F + f, from nested counters (f innermost), no multiplier in datapath; wraps modulo 2^ADDR_W.
// - States: IDLE -> (start) RECV; RECV -> (transfer, pass>0) READ; READ -> WRITE; WRITE -> RECV;
//   RECV -> DONE after the last word of pass N_PASS-1 is written; DONE -> IDLE (done=1 for that cycle).
// - Pass 0: psum_ready=1 in RECV; transfer writes wr_data=psum_data, wr_en same cycle as transfer (registered
//   outputs, so wr_en visible the next cycle); throughput 1 word/cycle.
// - Pass >0: transfer latches psum, issues rd_en/rd_addr; psum_ready=0 in READ and WRITE; in WRITE,
//   wr_data = rd_data + latched psum, modulo 2^DATA_W (wrap, no saturation); throughput 1 word/3 cycles.
// - Counter end: f wraps to 0 at F-1, e increments; e wraps at E-1, m increments; m wraps at M-1 ends pass.
// - psum_last on a word that is not the pass end, or missing on the pass end: set err; counters follow
//   their own count (psum_last not used for sequencing).
// - M, E, F or N_PASS = 0 on start: no transfers; go straight to DONE (done pulses 2 cycles after start).
// - start while busy: ignored. psum_valid in IDLE/DONE: not accepted (psum_ready=0).
// - rst asserted mid-layer: immediate return to reset state; partial bank contents undefined, no done.
// - Read and write to same address never overlap: write of word n completes before read of word n+1.
// TESTING
// - Reset: assert rst mid-RECV -> all outputs 0 next edge, busy=0, no done pulse.
// - M=1,E=3,F=3,N_PASS=1, psums 1..9 back-to-back -> wr_addr 0..8, wr_data 1..9, 9 consecutive writes, done once.
// - M=2,E=2,F=2,N_PASS=2, pass0 all 5, pass1 all 7 -> bank addr 0..7 = 12; pass1 psum_ready duty 1/3.
// - Wrap: pass0 0xFFF0, pass1 0x0020 at addr 0 -> final 0x0010.
// - psum_last on 3rd of 4 words -> err=1, writes still 4 per pass; next start clears err.
// - start with E=0 -> no wr_en, done pulse 2 cycles later; start during busy -> no effect on counters.

Source files
------------

// File: rtl/ofmap_writer_if.sv
// Bus between the psum drain side, the ofmap bank and layer control.
// The writer takes the slave view; the upstream / bank side takes the master view.
interface ofmap_writer_if #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 12
);
  logic [DIM_W-1:0]  M, E, F, N_PASS;
  logic              start;
  logic              psum_valid;
  logic              psum_ready;
  logic [DATA_W-1:0] psum_data;
  logic              psum_last;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  M, E, F, N_PASS, start, psum_valid, psum_data, psum_last, rd_data,
    output psum_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport master (
    output M, E, F, N_PASS, start, psum_valid, psum_data, psum_last, rd_data,
    input  psum_ready, rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/ofmap_writer.sv
// ofmap_writer: drains the PE-array psum stream into the ofmap bank.
// Pass 0 writes psums straight through at 1 word/cycle; later passes do a
// read-modify-write (RECV -> READ -> WRITE) so the bank accumulates channel
// passes. The bank address is a running counter since the stream order
// (m, e, f with f innermost) matches the bank's filter-major row-major layout;
// the nested m/e/f counters only detect the pass end.
module ofmap_writer #(
  parameter int DATA_W = 16,
  parameter int DIM_W  = 8,
  parameter int ADDR_W = 12
) (
  input logic          clk,
  input logic          rst,
  ofmap_writer_if.slave bus
);

  localparam logic [DIM_W-1:0]  ONE_D = 1;
  localparam logic [ADDR_W-1:0] ONE_A = 1;

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_READ, S_WRITE, S_DONE} state_t;

  state_t            r_state;
  logic [DIM_W-1:0]  r_m_dim, r_e_dim, r_f_dim, r_np;
  logic [DIM_W-1:0]  r_m, r_e, r_f, r_pass;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_psum;
  logic              r_zero, r_fin;
  logic              r_ready, r_rd_en, r_wr_en, r_busy, r_done, r_err;
  logic [ADDR_W-1:0] r_rd_addr, r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;

  logic w_xfer, w_f_end, w_e_end, w_m_end, w_word_end, w_last_pass, w_fin;

  // r_ready is only ever high in RECV, so it fully qualifies a transfer
  assign w_xfer      = bus.psum_valid && r_ready;
  assign w_f_end     = (r_f == r_f_dim - ONE_D);
  assign w_e_end     = (r_e == r_e_dim - ONE_D);
  assign w_m_end     = (r_m == r_m_dim - ONE_D);
  assign w_word_end  = w_f_end && w_e_end && w_m_end;
  assign w_last_pass = (r_pass == r_np - ONE_D);
  assign w_fin       = w_word_end && w_last_pass;

  assign bus.psum_ready = r_ready;
  assign bus.rd_en      = r_rd_en;
  assign bus.rd_addr    = r_rd_addr;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

  // Layer FSM with registered outputs; strobes default low each cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m_dim   <= '0; r_e_dim <= '0; r_f_dim <= '0; r_np <= '0;
      r_m       <= '0; r_e <= '0; r_f <= '0; r_pass <= '0;
      r_addr    <= '0;
      r_psum    <= '0;
      r_zero    <= 1'b0;
      r_fin     <= 1'b0;
      r_ready   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_m_dim <= bus.M; r_e_dim <= bus.E; r_f_dim <= bus.F; r_np <= bus.N_PASS;
          r_m     <= '0; r_e <= '0; r_f <= '0; r_pass <= '0;
          r_addr  <= '0;
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_zero  <= (bus.M == '0) || (bus.E == '0) || (bus.F == '0) || (bus.N_PASS == '0);
          r_ready <= !((bus.M == '0) || (bus.E == '0) || (bus.F == '0) || (bus.N_PASS == '0));
          r_state <= S_RECV;
        end
        S_RECV: begin
          if (r_zero) begin
            // degenerate layer: nothing to move, finish immediately
            r_ready <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_xfer) begin
            // psum_last is only checked, never used to sequence
            if (bus.psum_last != w_word_end) r_err <= 1'b1;
            if (w_f_end) begin
              r_f <= '0;
              if (w_e_end) begin
                r_e <= '0;
                if (w_m_end) r_m <= '0;
                else         r_m <= r_m + ONE_D;
              end else r_e <= r_e + ONE_D;
            end else r_f <= r_f + ONE_D;
            r_addr    <= w_word_end ? '0 : r_addr + ONE_A;
            if (w_word_end) r_pass <= r_pass + ONE_D;
            r_wr_addr <= r_addr;
            if (r_pass == '0) begin
              r_wr_en   <= 1'b1;
              r_wr_data <= bus.psum_data;
              if (w_fin) begin
                r_ready <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_psum    <= bus.psum_data;
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_addr;
              r_fin     <= w_fin;
              r_ready   <= 1'b0;
              r_state   <= S_READ;
            end
          end
        end
        S_READ: r_state <= S_WRITE;
        // rd_data is valid this cycle; the write lands before the next read
        S_WRITE: begin
          r_wr_en   <= 1'b1;
          r_wr_data <= bus.rd_data + r_psum;
          if (r_fin) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_RECV;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
